// File: rtl/br_lite_local_if_pkg.sv
// Shared BrLite flit and service definitions.
package br_lite_local_if_pkg;

    localparam int unsigned SEQ_W     = 16;
    localparam int unsigned ID_W      = 4;
    localparam int unsigned PAYLOAD_W = 8;

    typedef enum logic [1:0] {
        BR_SVC_ALL   = 2'd0,
        BR_SVC_TGT   = 2'd1,
        BR_SVC_MON   = 2'd2,
        BR_SVC_CLEAR = 2'd3
    } br_svc_t;

    typedef logic [PAYLOAD_W-1:0] br_payload_t;

    typedef struct packed {
        logic [SEQ_W-1:0] seq_source;
        logic [SEQ_W-1:0] seq_target;
        br_svc_t          service;
        logic [ID_W-1:0]  id;
        br_payload_t      payload;
    } br_data_t;

endpackage

// File: rtl/br_lite_fifo.sv
// Small power-of-two FIFO; push is ignored when full, pop when empty.
module br_lite_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/br_lite_local_if.sv
// PE-side adapter for the BrLite router LOCAL port: TX injection FSM and RX buffer.
module br_lite_local_if
    import br_lite_local_if_pkg::*;
#(
    parameter logic [SEQ_W-1:0] SEQ_ADDRESS = 16'd0,
    parameter int unsigned      RX_DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    input  br_svc_t     tx_service_i,
    input  logic [15:0] tx_target_i,
    input  br_payload_t tx_payload_i,
    output logic        tx_err_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output br_data_t    rx_flit_o,
    input  logic        local_busy_i,
    output br_data_t    flit_o,
    output logic        req_o,
    input  logic        ack_i,
    input  br_data_t    flit_i,
    input  logic        req_i,
    output logic        ack_o
);

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_REQ  = 1'b1;

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic            req_d;
    logic            err_d;
    br_data_t        flit_d;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] id_d;
    logic            tx_ready_c;

    logic            fifo_full;
    logic            fifo_empty;
    logic            rx_accept_c;
    logic            rx_push_c;
    logic            rx_is_clear_c;

    // TX next-state and output decode.
    always_comb begin
        state_d    = state_q;
        req_d      = req_o;
        err_d      = 1'b0;
        flit_d     = flit_o;
        id_d       = id_q;
        tx_ready_c = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_ready_c = rst_ni && !local_busy_i;
                if (tx_valid_i && tx_ready_c) begin
                    if (tx_service_i == BR_SVC_CLEAR) begin
                        err_d = 1'b1;
                    end else begin
                        flit_d.seq_source = SEQ_ADDRESS;
                        flit_d.seq_target = tx_target_i;
                        flit_d.service    = tx_service_i;
                        flit_d.id         = id_q;
                        flit_d.payload    = tx_payload_i;
                        req_d             = 1'b1;
                        state_d           = TX_REQ;
                    end
                end
            end
            TX_REQ: begin
                if (ack_i) begin
                    req_d   = 1'b0;
                    id_d    = id_q + ID_W'(1);
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign tx_ready_o = tx_ready_c;

    // CLEAR flits are acked without taking a FIFO slot, so fullness does not block them.
    assign rx_is_clear_c = (flit_i.service == BR_SVC_CLEAR);
    assign rx_accept_c   = req_i && !ack_o && (rx_is_clear_c || !fifo_full);
    assign rx_push_c     = rx_accept_c && !rx_is_clear_c;
    assign rx_valid_o    = !fifo_empty;

    // State and registered outputs for both directions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= TX_IDLE;
            req_o    <= 1'b0;
            flit_o   <= '0;
            tx_err_o <= 1'b0;
            id_q     <= '0;
            ack_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_o    <= req_d;
            flit_o   <= flit_d;
            tx_err_o <= err_d;
            id_q     <= id_d;
            ack_o    <= rx_accept_c;
        end
    end

    br_lite_fifo #(
        .DEPTH (RX_DEPTH),
        .T     (br_data_t)
    ) u_rx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (rx_push_c),
        .din    (flit_i),
        .pop    (rx_ready_i),
        .dout   (rx_flit_o),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: doc/br_lite_local_if.md
# br_lite_local_if

Local-port adapter between a processing element and the BrLite broadcast router's LOCAL port. On the TX side it turns PE broadcast requests into router flits: it stamps the source address and a rolling id, drives the LOCAL input req/ack handshake, and honours the router's local-busy interlock. On the RX side it accepts flits the router delivers on its LOCAL output, acks them, and buffers them in a small FIFO drained by the PE through a valid/ready interface.

## Interface
- SEQ_ADDRESS, 16'd0, sequential address of this PE; written into seq_source of every injected flit.
- RX_DEPTH, 4, RX FIFO depth; power of 2, ≥2.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- tx_valid_i  in  1  PE broadcast request valid.
- tx_ready_o  out  1  request accepted this cycle when high together with tx_valid_i.
- tx_service_i  in  br_svc_t  service (ALL, TGT, MON; CLEAR is illegal).
- tx_target_i  in  16  seq_target of the flit.
- tx_payload_i  in  br_payload_t  payload.
- tx_err_o  out  1  one-cycle pulse: illegal CLEAR request dropped.
- rx_valid_o  out  1  FIFO head valid.
- rx_ready_i  in  1  PE pops head.
- rx_flit_o  out  br_data_t  FIFO head.
- local_busy_i  in  1  router local-busy (previous local broadcast not yet cleared).
- flit_o  out  br_data_t  to router LOCAL flit input.
- req_o  out  1  to router LOCAL req input.
- ack_i  in  1  from router LOCAL ack output.
- flit_i  in  br_data_t  from router LOCAL flit output.
- req_i  in  1  from router LOCAL req output.
- ack_o  out  1  to router LOCAL ack input.

## Operation
- TX FSM states TX_IDLE, TX_REQ.
- TX_IDLE: tx_ready_o = !local_busy_i. On accept with a legal service: flit_o is registered as {seq_source=SEQ_ADDRESS, seq_target=tx_target_i, service, id=id_cnt, payload}, req_o is set and the FSM moves to TX_REQ. On accept with CLEAR: tx_err_o pulses, no flit is produced, the FSM stays in TX_IDLE and id_cnt is unchanged.
- TX_REQ: tx_ready_o = 0; req_o and flit_o are held stable. On ack_i: req_o is cleared, id_cnt increments (wraps modulo 2^id width), and the FSM returns to TX_IDLE.
- RX: push when req_i && !ack_o && !full. A push registers ack_o = 1 for exactly one cycle. CLEAR flits that arrive are acked but not pushed.
- FIFO: rx_valid_o = !empty. A pop occurs when rx_valid_o && rx_ready_i. Simultaneous push and pop leaves the count unchanged. Full is evaluated before the same-cycle pop, so the RX side never pushes while full.

## Timing
- Reset values: tx_ready_o 0 during reset, then follows !local_busy_i. tx_err_o, req_o, ack_o, rx_valid_o are 0. flit_o is all zeros, rx_flit_o is don't-care. id_cnt is 0, FIFO is empty, TX FSM is TX_IDLE.
- TX: accept at cycle t → req_o is high from t+1. ack_i at cycle u → req_o is low at u+1, so the router sees req low when it re-evaluates. The earliest next accept is u+1, and only if local_busy_i is low.
- RX: req_i first high at t (FIFO not full) → flit captured at the edge ending t, ack_o high in t+1, low in t+2. req_i still high in t+1 must not cause a second push.
- FIFO full: ack_o is withheld and the router stalls in its local-output wait; the first pop reopens pushes the following cycle.
- Reset mid-handshake: all state clears immediately and any in-flight TX request is lost. The router is reset by the same rst_ni.
- Read latency: a flit pushed at edge e is visible on rx_valid_o/rx_flit_o after e.

## Structure
- br_data_t, br_svc_t, br_payload_t, BR_SVC_* and the id field width all come from the shared BrLite package. No new package types are needed.
- Sub-module br_lite_fifo (parameters DEPTH and element type br_data_t, with push/pop/full/empty) holds the RX buffer. TX and RX control live in the top module.

## Test plan
- tx SVC_ALL, target 5, payload 0xAB, local_busy_i 0 → req_o high next cycle; flit_o has seq_source = SEQ_ADDRESS and id 0; ack_i pulse → req_o low next cycle; the next send carries id 1.
- local_busy_i = 1 with tx_valid_i held → tx_ready_o 0 and no req_o until busy drops; tx_ready_o rises the same cycle busy drops.
- tx CLEAR → tx_err_o single pulse, req_o stays 0, id_cnt unchanged.
- Router presents RX_DEPTH+1 flits with rx_ready_i = 0 → RX_DEPTH ack_o pulses, each one cycle, with no double push; the last req_i stays unacked. One pop → ack on the following cycle; FIFO order is preserved.
- Incoming CLEAR flit → acked in one cycle and rx_valid_o unchanged. Drive id_cnt to its maximum value and send → the next id is 0.
